// File: rtl/scanner_pkg.sv
// Shared state encodings for the scanner channel array.
package scanner_pkg;
  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    LOW_POWER = 3'b000,
    STANDBY   = 3'b001,
    SCANNING  = 3'b010,
    IDLE      = 3'b011,
    XFERRING  = 3'b100,
    FLUSHING  = 3'b101
  } scan_st_e;
endpackage

// File: rtl/scanner_channel.sv
// One scanner channel: lifecycle FSM and progress counter.
module scanner_channel
  import scanner_pkg::*;
#(
  parameter int PROG_W   = 4,
  parameter int PROG_MAX = 10,
  parameter int WAKE_AT  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wake,
  input  logic              i_handoff,
  input  logic              i_launch,
  input  logic              i_grant,
  input  logic              i_flush_req,
  output scan_st_e          o_state,
  output logic [PROG_W-1:0] o_prog,
  output logic              o_wake_out,
  output logic              o_done_out
);
  scan_st_e          r_state;
  logic [PROG_W-1:0] r_prog;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOW_POWER;
      r_prog  <= '0;
    end else begin
      case (r_state)
        LOW_POWER: begin
          if (i_launch) begin
            r_state <= SCANNING;
            r_prog  <= '0;
          end else if (i_wake) begin
            r_state <= STANDBY;
          end
        end
        STANDBY: begin
          if (i_handoff) begin
            r_state <= SCANNING;
            r_prog  <= '0;
          end
        end
        SCANNING: begin
          if (r_prog == PROG_W'(PROG_MAX)) r_state <= IDLE;
          else                             r_prog  <= r_prog + PROG_W'(1);
        end
        IDLE: begin
          if (i_grant)          r_state <= XFERRING;
          else if (i_flush_req) r_state <= FLUSHING;
        end
        XFERRING: begin
          if (r_prog == '0) r_state <= LOW_POWER;
          else              r_prog  <= r_prog - PROG_W'(1);
        end
        FLUSHING: begin
          // Step by two but land exactly on zero for odd counts.
          if (r_prog == '0)                r_state <= LOW_POWER;
          else if (r_prog < PROG_W'(2))    r_prog  <= '0;
          else                             r_prog  <= r_prog - PROG_W'(2);
        end
        default: begin
          r_state <= LOW_POWER;
          r_prog  <= '0;
        end
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_prog     = r_prog;
  assign o_wake_out = (r_state == SCANNING) && (r_prog == PROG_W'(WAKE_AT));
  assign o_done_out = (r_state == SCANNING) && (r_prog == PROG_W'(PROG_MAX));
endmodule

// File: rtl/scanner_array_ctrl.sv
// Ring of scanner channels: launch select, scan handoff, overrun detect and
// round-robin arbitration of the shared transfer bus.
module scanner_array_ctrl
  import scanner_pkg::*;
#(
  parameter int NUM_SCAN = 2,
  parameter int PROG_W   = 4,
  parameter int PROG_MAX = 10,
  parameter int WAKE_AT  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
  input  logic [NUM_SCAN-1:0]        i_xfer_req,
  input  logic [NUM_SCAN-1:0]        i_flush_req,
  output logic [ST_W*NUM_SCAN-1:0]   o_state,
  output logic [PROG_W*NUM_SCAN-1:0] o_prog,
  output logic [NUM_SCAN-1:0]        o_xfer_grant,
  output logic                       o_active,
  output logic                       o_overrun
);
  localparam int PTR_W = $clog2(NUM_SCAN);

  scan_st_e            w_st [NUM_SCAN];
  logic [NUM_SCAN-1:0] w_wake, w_done, w_launch, w_grant, w_cand, w_ovr_ch;
  logic [NUM_SCAN-1:0] w_is_scan, w_is_stby, w_is_lp, w_is_xfer;
  logic [PTR_W-1:0]    r_ptr, w_ptr_nxt, w_idx;
  logic                r_overrun;

  for (genvar g = 0; g < NUM_SCAN; g++) begin : g_ch
    localparam int PRED = (g + NUM_SCAN - 1) % NUM_SCAN;
    localparam int SUCC = (g + 1) % NUM_SCAN;

    scanner_channel #(
      .PROG_W  (PROG_W),
      .PROG_MAX(PROG_MAX),
      .WAKE_AT (WAKE_AT)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .i_wake     (w_wake[PRED]),
      .i_handoff  (w_done[PRED]),
      .i_launch   (w_launch[g]),
      .i_grant    (w_grant[g]),
      .i_flush_req(i_flush_req[g] & ~i_xfer_req[g]),
      .o_state    (w_st[g]),
      .o_prog     (o_prog[PROG_W*g +: PROG_W]),
      .o_wake_out (w_wake[g]),
      .o_done_out (w_done[g])
    );

    assign o_state[ST_W*g +: ST_W] = w_st[g];
    assign w_is_scan[g] = (w_st[g] == SCANNING);
    assign w_is_stby[g] = (w_st[g] == STANDBY);
    assign w_is_lp[g]   = (w_st[g] == LOW_POWER);
    assign w_is_xfer[g] = (w_st[g] == XFERRING);
    assign w_cand[g]    = (w_st[g] == IDLE) & i_xfer_req[g];
    // Handoff fails when the successor was not waiting in STANDBY.
    assign w_ovr_ch[g]  = w_done[g] & (w_st[SUCC] != STANDBY);
  end

  // Lowest-index LOW_POWER channel wins; descending overwrite keeps the lowest.
  always_comb begin
    w_launch = '0;
    if (i_start && !(|w_is_scan) && !(|w_is_stby))
      for (int i = NUM_SCAN - 1; i >= 0; i--)
        if (w_is_lp[i]) w_launch = NUM_SCAN'(1) << i;
  end

  always_comb begin
    w_grant   = '0;
    w_ptr_nxt = r_ptr;
    w_idx     = '0;
    if (!(|w_is_xfer))
      for (int k = NUM_SCAN - 1; k >= 0; k--) begin
        w_idx = PTR_W'((int'(r_ptr) + k) % NUM_SCAN);
        if (w_cand[w_idx]) begin
          w_grant        = '0;
          w_grant[w_idx] = 1'b1;
          w_ptr_nxt      = PTR_W'((int'(w_idx) + 1) % NUM_SCAN);
        end
      end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= |w_ovr_ch;
      if (|w_grant) r_ptr <= w_ptr_nxt;
    end
  end

  assign o_xfer_grant = w_is_xfer;
  assign o_active     = |w_is_scan;
  assign o_overrun    = r_overrun;
endmodule

// File: tb/tb_scanner_array_ctrl.sv
// Directed bench: a 2-channel (PROG_MAX 10) and a 3-channel (PROG_MAX 9) array.
module tb_scanner_array_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a;
  logic [1:0] xr_a, fr_a, gr_a;
  logic [5:0] st_a;
  logic [7:0] pr_a;
  logic       act_a, ovr_a;

  logic        rst_b, start_b;
  logic [2:0]  xr_b, fr_b, gr_b;
  logic [8:0]  st_b;
  logic [11:0] pr_b;
  logic        act_b, ovr_b;

  int n_checks = 0;
  int n_err    = 0;

  scanner_array_ctrl #(.NUM_SCAN(2), .PROG_W(4), .PROG_MAX(10), .WAKE_AT(8)) u_a (
    .clk(clk), .reset(rst_a), .i_start(start_a), .i_xfer_req(xr_a), .i_flush_req(fr_a),
    .o_state(st_a), .o_prog(pr_a), .o_xfer_grant(gr_a), .o_active(act_a), .o_overrun(ovr_a)
  );

  scanner_array_ctrl #(.NUM_SCAN(3), .PROG_W(4), .PROG_MAX(9), .WAKE_AT(7)) u_b (
    .clk(clk), .reset(rst_b), .i_start(start_b), .i_xfer_req(xr_b), .i_flush_req(fr_b),
    .o_state(st_b), .o_prog(pr_b), .o_xfer_grant(gr_b), .o_active(act_b), .o_overrun(ovr_b)
  );

  function automatic logic [2:0] sa(input int i); return st_a[3*i +: 3]; endfunction
  function automatic logic [3:0] pa(input int i); return pr_a[4*i +: 4]; endfunction
  function automatic logic [2:0] sb(input int i); return st_b[3*i +: 3]; endfunction
  function automatic logic [3:0] pb(input int i); return pr_b[4*i +: 4]; endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int fl_a [5] = '{8, 6, 4, 2, 0};
    int fl_b [5] = '{7, 5, 3, 1, 0};
    rst_a = 1; start_a = 0; xr_a = '0; fr_a = '0;
    rst_b = 1; start_b = 0; xr_b = '0; fr_b = '0;
    step(); step();
    chk("a_rst_state", st_a, 0);
    chk("a_rst_prog", pr_a, 0);
    chk("a_rst_grant", gr_a, 0);
    chk("a_rst_active", act_a, 0);
    chk("a_rst_overrun", ovr_a, 0);

    // launch ch0
    rst_a = 0; start_a = 1; step(); start_a = 0;
    chk("a_launch_ch0_st", sa(0), 3'b010);
    chk("a_launch_ch0_prog", pa(0), 0);
    chk("a_launch_ch1_st", sa(1), 3'b000);
    chk("a_launch_active", act_a, 1);

    // wake at 8, handoff at 10
    repeat (8) step();
    chk("a_ch0_prog8", pa(0), 8);
    chk("a_ch1_still_lp", sa(1), 3'b000);
    step();
    chk("a_ch1_standby", sa(1), 3'b001);
    step(); step();
    chk("a_ch0_idle", sa(0), 3'b011);
    chk("a_ch0_prog_held", pa(0), 10);
    chk("a_ch1_scanning", sa(1), 3'b010);
    chk("a_ch1_prog0", pa(1), 0);
    chk("a_handoff_no_ovr", ovr_a, 0);
    chk("a_handoff_active", act_a, 1);

    // ch0 held IDLE: ch1 handoff fails
    repeat (10) step();
    chk("a_ch1_prog10", pa(1), 10);
    chk("a_ch1_pre_ovr", ovr_a, 0);
    step();
    chk("a_overrun_pulse", ovr_a, 1);
    chk("a_ovr_ch1_idle", sa(1), 3'b011);
    chk("a_ovr_ch0_idle", sa(0), 3'b011);
    chk("a_ovr_active", act_a, 0);
    step();
    chk("a_overrun_clear", ovr_a, 0);
    start_a = 1; step(); start_a = 0;
    chk("a_start_ignored_ch0", sa(0), 3'b011);
    chk("a_start_ignored_act", act_a, 0);

    // flush ch0 from 10
    fr_a = 2'b01; step(); fr_a = '0;
    chk("a_flush_enter", sa(0), 3'b101);
    chk("a_flush_p10", pa(0), 10);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("a_flush_prog", pa(0), fl_a[i]);
      chk("a_flush_state", sa(0), 3'b101);
    end
    step();
    chk("a_flush_done_st", sa(0), 3'b000);
    start_a = 1; step(); start_a = 0;
    chk("a_relaunch_st", sa(0), 3'b010);
    chk("a_relaunch_prog", pa(0), 0);
    chk("a_relaunch_ch1", sa(1), 3'b011);

    // ch1 IDLE again, so ch0 overruns
    repeat (10) step();
    step();
    chk("a_ovr2_ch0_idle", sa(0), 3'b011);
    chk("a_ovr2_pulse", ovr_a, 1);

    // xfer wins over flush
    xr_a = 2'b01; fr_a = 2'b01; step(); xr_a = '0; fr_a = '0;
    chk("a_xfer_pri_st", sa(0), 3'b100);
    chk("a_xfer_grant", gr_a, 2'b01);
    chk("a_xfer_p10", pa(0), 10);
    step();
    chk("a_xfer_p9", pa(0), 9);
    repeat (4) step();
    chk("a_xfer_p5", pa(0), 5);
    chk("a_xfer_p5_st", sa(0), 3'b100);

    // reset mid-transfer with start high
    rst_a = 1; start_a = 1; step();
    chk("a_midrst_state", st_a, 0);
    chk("a_midrst_prog", pr_a, 0);
    chk("a_midrst_grant", gr_a, 0);
    chk("a_midrst_active", act_a, 0);
    rst_a = 0; step(); start_a = 0;
    chk("a_postrst_ch0", sa(0), 3'b010);
    chk("a_postrst_prog", pa(0), 0);
    chk("a_postrst_ch1", sa(1), 3'b000);

    // three-channel ring, PROG_MAX 9, WAKE_AT 7
    rst_b = 0; start_b = 1; step(); start_b = 0;
    chk("b_launch_ch0", sb(0), 3'b010);
    repeat (7) step();
    chk("b_ch0_p7", pb(0), 7);
    chk("b_ch1_lp", sb(1), 3'b000);
    step();
    chk("b_ch1_standby", sb(1), 3'b001);
    step(); step();
    chk("b_ch0_idle", sb(0), 3'b011);
    chk("b_ch0_p9", pb(0), 9);
    chk("b_ch1_scan", sb(1), 3'b010);
    repeat (10) step();
    chk("b_ch1_idle", sb(1), 3'b011);
    chk("b_ch2_scan", sb(2), 3'b010);
    chk("b_ch0_unwoken", sb(0), 3'b011);
    repeat (10) step();
    chk("b_ch2_idle", sb(2), 3'b011);
    chk("b_overrun", ovr_b, 1);
    chk("b_inactive", act_b, 0);

    // ch0 and ch2 both request; pointer 0 picks ch0 first
    xr_b = 3'b101; step();
    chk("b_arb_ch0", sb(0), 3'b100);
    chk("b_arb_grant0", gr_b, 3'b001);
    chk("b_arb_p9", pb(0), 9);
    chk("b_arb_ch2_wait", sb(2), 3'b011);
    repeat (9) step();
    chk("b_ch0_p0", pb(0), 0);
    chk("b_ch0_p0_st", sb(0), 3'b100);
    chk("b_ch2_still_wait", sb(2), 3'b011);
    step();
    chk("b_ch0_lp", sb(0), 3'b000);
    chk("b_grant_gap", gr_b, 3'b000);
    step();
    chk("b_ch2_xfer", sb(2), 3'b100);
    chk("b_grant2", gr_b, 3'b100);
    chk("b_ch2_p9", pb(2), 9);

    // odd flush from 9 saturates at 0, alongside ch2 transfer
    xr_b = '0; fr_b = 3'b010; step(); fr_b = '0;
    chk("b_flush_enter", sb(1), 3'b101);
    chk("b_flush_p9", pb(1), 9);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("b_flush_prog", pb(1), fl_b[i]);
    end
    step();
    chk("b_flush_done", sb(1), 3'b000);
    chk("b_ch2_p2", pb(2), 2);
    chk("b_ch2_grant_kept", gr_b, 3'b100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
